// File: rtl/decode_stage_if.sv
// Decode-stage bus: IF/ID inputs, writeback port, hazard controls and ID/EX outputs.
interface decode_stage_if;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC_Plus_4_D;
  logic        Reg_Write_W;
  logic [4:0]  Rd_W;
  logic [31:0] Result_W;
  logic        Flush_E;
  logic        Stall_E;
  logic [4:0]  Rs1_D;
  logic [4:0]  Rs2_D;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] Imm_E;
  logic [4:0]  Rs1_E;
  logic [4:0]  Rs2_E;
  logic [4:0]  Rd_E;
  logic [31:0] PC_E;
  logic [31:0] PC_Plus_4_E;
  logic [2:0]  Funct3_E;
  logic        Reg_Write_E;
  logic        Mem_Write_E;
  logic        Branch_E;
  logic        Jump_E;
  logic        ALU_Src_E;
  logic        ALU_A_Src_E;
  logic [1:0]  Result_Src_E;
  logic [3:0]  ALU_Ctrl_E;

  modport master (
    output Instr_D, PC_D, PC_Plus_4_D, Reg_Write_W, Rd_W, Result_W, Flush_E, Stall_E,
    input  Rs1_D, Rs2_D, RD1_E, RD2_E, Imm_E, Rs1_E, Rs2_E, Rd_E, PC_E, PC_Plus_4_E,
    input  Funct3_E, Reg_Write_E, Mem_Write_E, Branch_E, Jump_E, ALU_Src_E, ALU_A_Src_E,
    input  Result_Src_E, ALU_Ctrl_E
  );

  modport slave (
    input  Instr_D, PC_D, PC_Plus_4_D, Reg_Write_W, Rd_W, Result_W, Flush_E, Stall_E,
    output Rs1_D, Rs2_D, RD1_E, RD2_E, Imm_E, Rs1_E, Rs2_E, Rd_E, PC_E, PC_Plus_4_E,
    output Funct3_E, Reg_Write_E, Mem_Write_E, Branch_E, Jump_E, ALU_Src_E, ALU_A_Src_E,
    output Result_Src_E, ALU_Ctrl_E
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: register file, control/immediate decode, ID/EX register.
// Optional REGFILE_BYPASS_EN: same-cycle writeback-to-read forwarding in the register file.
module decode_stage (
  input logic           CLK,
  input logic           RST,
  decode_stage_if.slave bus
);
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSll  = 4'b0101;
  localparam logic [3:0] AluSrl  = 4'b0110;
  localparam logic [3:0] AluSra  = 4'b0111;
  localparam logic [3:0] AluSlt  = 4'b1000;
  localparam logic [3:0] AluSltu = 4'b1001;
  localparam logic [3:0] AluPass = 4'b1010;

  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_sel_e;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [2:0]  funct3;
    logic        reg_write;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src;
    logic        alu_a_src;
    logic [1:0]  result_src;
    logic [3:0]  alu_ctrl;
  } idex_t;

  logic [31:0] instr;
  logic [31:0] regs [32];
  logic [31:0] rd1, rd2, imm;
  imm_sel_e    imm_sel;
  idex_t       idex_d, idex_q;
  idex_t       ctl;

  assign instr     = bus.Instr_D;
  assign bus.Rs1_D = instr[19:15];
  assign bus.Rs2_D = instr[24:20];

  // R-type and I-ALU share funct3 decoding; only R-type honours funct7[5] for SUB.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b5,
                                        input logic is_r);
    case (f3)
      3'b000:  alu_op = (is_r && f7b5) ? AluSub : AluAdd;
      3'b001:  alu_op = AluSll;
      3'b010:  alu_op = AluSlt;
      3'b011:  alu_op = AluSltu;
      3'b100:  alu_op = AluXor;
      3'b101:  alu_op = f7b5 ? AluSra : AluSrl;
      3'b110:  alu_op = AluOr;
      default: alu_op = AluAnd;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.Reg_Write_W && (bus.Rd_W != 5'd0)) begin
      regs[bus.Rd_W] <= bus.Result_W;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd1 = (bus.Rs1_D == 5'd0) ? '0 : regs[bus.Rs1_D];
    rd2 = (bus.Rs2_D == 5'd0) ? '0 : regs[bus.Rs2_D];
    if (bus.Reg_Write_W && (bus.Rd_W != 5'd0) && (bus.Rd_W == bus.Rs1_D)) rd1 = bus.Result_W;
    if (bus.Reg_Write_W && (bus.Rd_W != 5'd0) && (bus.Rd_W == bus.Rs2_D)) rd2 = bus.Result_W;
  end
`else
  assign rd1 = (bus.Rs1_D == 5'd0) ? '0 : regs[bus.Rs1_D];
  assign rd2 = (bus.Rs2_D == 5'd0) ? '0 : regs[bus.Rs2_D];
`endif

  always_comb begin
    ctl     = '0;
    imm_sel = ImmNone;
    case (instr[6:0])
      OpR: begin
        ctl.reg_write = 1'b1;
        ctl.alu_ctrl  = alu_op(instr[14:12], instr[30], 1'b1);
      end
      OpI: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src   = 1'b1;
        ctl.alu_ctrl  = alu_op(instr[14:12], instr[30], 1'b0);
        imm_sel       = ImmI;
      end
      OpLoad: begin
        ctl.reg_write  = 1'b1;
        ctl.result_src = 2'b01;
        ctl.alu_src    = 1'b1;
        imm_sel        = ImmI;
      end
      OpStore: begin
        ctl.mem_write = 1'b1;
        ctl.alu_src   = 1'b1;
        imm_sel       = ImmS;
      end
      OpBr: begin
        ctl.branch   = 1'b1;
        ctl.alu_ctrl = instr[14] ? (instr[13] ? AluSltu : AluSlt) : AluSub;
        imm_sel      = ImmB;
      end
      OpJal: begin
        ctl.reg_write  = 1'b1;
        ctl.result_src = 2'b10;
        ctl.alu_src    = 1'b1;
        ctl.alu_a_src  = 1'b1;
        ctl.jump       = 1'b1;
        imm_sel        = ImmJ;
      end
      OpJalr: begin
        ctl.reg_write  = 1'b1;
        ctl.result_src = 2'b10;
        ctl.alu_src    = 1'b1;
        ctl.jump       = 1'b1;
        imm_sel        = ImmI;
      end
      OpLui: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src   = 1'b1;
        ctl.alu_ctrl  = AluPass;
        imm_sel       = ImmU;
      end
      OpAuipc: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src   = 1'b1;
        ctl.alu_a_src = 1'b1;
        imm_sel       = ImmU;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm = '0;
    case (imm_sel)
      ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
      ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmU:    imm = {instr[31:12], 12'b0};
      ImmJ:    imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  always_comb begin
    idex_d = idex_q;
    if (RST || bus.Flush_E) begin
      idex_d = '0;
    end else if (!bus.Stall_E) begin
      idex_d        = ctl;
      idex_d.rd1    = rd1;
      idex_d.rd2    = rd2;
      idex_d.imm    = imm;
      idex_d.rs1    = instr[19:15];
      idex_d.rs2    = instr[24:20];
      idex_d.rd     = instr[11:7];
      idex_d.pc     = bus.PC_D;
      idex_d.pc4    = bus.PC_Plus_4_D;
      idex_d.funct3 = instr[14:12];
    end
  end

  always_ff @(posedge CLK) idex_q <= idex_d;

  assign bus.RD1_E        = idex_q.rd1;
  assign bus.RD2_E        = idex_q.rd2;
  assign bus.Imm_E        = idex_q.imm;
  assign bus.Rs1_E        = idex_q.rs1;
  assign bus.Rs2_E        = idex_q.rs2;
  assign bus.Rd_E         = idex_q.rd;
  assign bus.PC_E         = idex_q.pc;
  assign bus.PC_Plus_4_E  = idex_q.pc4;
  assign bus.Funct3_E     = idex_q.funct3;
  assign bus.Reg_Write_E  = idex_q.reg_write;
  assign bus.Mem_Write_E  = idex_q.mem_write;
  assign bus.Branch_E     = idex_q.branch;
  assign bus.Jump_E       = idex_q.jump;
  assign bus.ALU_Src_E    = idex_q.alu_src;
  assign bus.ALU_A_Src_E  = idex_q.alu_a_src;
  assign bus.Result_Src_E = idex_q.result_src;
  assign bus.ALU_Ctrl_E   = idex_q.alu_ctrl;
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Decode stage of the 5-stage RV32I pipeline. It sits directly downstream of the fetch stage's IF/ID register and consumes Instr_D, PC_D and PC_Plus_4_D. It contains:
- the 32x32 register file, written from writeback
- main/ALU control decode
- immediate generation
- the ID/EX pipeline register, with synchronous flush and stall

Parameters:
- NOP_INSTR, 32'h00000013, encoding treated as bubble (ADDI x0,x0,0)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- Instr_D  in  32  instruction from IF/ID
- PC_D  in  32  PC of Instr_D
- PC_Plus_4_D  in  32  PC+4 of Instr_D
- Reg_Write_W  in  1  writeback write enable
- Rd_W  in  5  writeback destination
- Result_W  in  32  writeback data
- Flush_E  in  1  insert bubble into EX
- Stall_E  in  1  hold ID/EX contents
- Rs1_D  out  5  Instr_D[19:15], combinational, for hazard unit
- Rs2_D  out  5  Instr_D[24:20], combinational, for hazard unit
- RD1_E, RD2_E  out  32  registered source operands
- Imm_E  out  32  registered sign-extended immediate
- Rs1_E, Rs2_E, Rd_E  out  5  registered register indices
- PC_E, PC_Plus_4_E  out  32  registered PCs
- Funct3_E  out  3  registered funct3 (branch/memory width)
- Reg_Write_E, Mem_Write_E, Branch_E, Jump_E, ALU_Src_E, ALU_A_Src_E  out  1  registered control
- Result_Src_E  out  2  00 ALU, 01 memory, 10 PC+4
- ALU_Ctrl_E  out  4  ALU operation code

Behaviour:
- Reset (RST=1 at posedge): all ID/EX outputs <= 0; all 32 registers <= 0. RST has priority over every other input.
- Register file:
  - write at posedge when Reg_Write_W=1 and Rd_W!=0.
  - x0 always reads 0; writes to x0 ignored.
  - reads combinational, indexed by Rs1_D/Rs2_D.
- ID/EX register priority: RST > Flush_E > Stall_E > load.
  - Flush_E: all outputs <= 0 (every control bit cleared, so no write/branch/jump), which forms a bubble.
  - Stall_E=1 and Flush_E=0: hold all outputs.
  - Otherwise: load the decoded values of the current Instr_D.
- Latency: one cycle, Instr_D to *_E outputs.
- Decode by opcode. Columns are Reg_Write / Mem_Write / Result_Src / ALU_Src / ALU_A_Src / Branch / Jump / imm type:
  - 0110011 R: 1/0/00/0/0/0/0/-
  - 0010011 I-ALU: 1/0/00/1/0/0/0/I
  - 0000011 load: 1/0/01/1/0/0/0/I, ALU ADD
  - 0100011 store: 0/1/00/1/0/0/0/S, ALU ADD
  - 1100011 branch: 0/0/00/0/0/1/0/B, ALU SUB (SLT/SLTU for funct3 1xx: 10x -> SLT, 11x -> SLTU)
  - 1101111 JAL: 1/0/10/1/1/0/1/J, ALU ADD (PC+imm)
  - 1100111 JALR: 1/0/10/1/0/0/1/I, ALU ADD
  - 0110111 LUI: 1/0/00/1/0/0/0/U, ALU PASS_B
  - 0010111 AUIPC: 1/0/00/1/1/0/0/U, ALU ADD
  - any other opcode: all control 0, treated as bubble
- ALU_Ctrl encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 PASS_B
- R-type: funct3 000 with funct7[5]=1 -> SUB.
- I-ALU: funct3 000 is always ADD (funct7 ignored). funct3 101 uses funct7[5]: 1 -> SRA, 0 -> SRL.
- Immediates, all sign-extended from Instr[31]:
  - I = [31:20]
  - S = {[31:25],[11:7]}
  - B = {[31],[7],[30:25],[11:8],0}
  - U = {[31:12],12'b0}
  - J = {[31],[19:12],[20],[30:21],0}
  - R-type: Imm_E = 0.
- Rd_E is always Instr_D[11:7], even for S/B types (their Reg_Write_E=0).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass. If Reg_Write_W=1, Rd_W!=0 and Rd_W==Rs1_D (resp. Rs2_D), the read data is Result_W in the same cycle. RD1_E/RD2_E then capture the new value.
- Undefined: reads return the array contents only. A same-cycle W->D dependency captures the stale value, and the hazard unit must stall D one extra cycle.

Test Plan:
- Reset: RST=1 for 2 cycles, then release with Instr_D=NOP_INSTR. Required: all *_E = 0 after reset; one cycle later Reg_Write_E=1, Rd_E=0, Imm_E=0, ALU_Ctrl_E=0000.
- Register write/read and x0:
  - Write x5=32'hDEADBEEF; then Instr_D=ADD x6,x5,x0 (32'h00028333). Required: RD1_E=32'hDEADBEEF, RD2_E=0, ALU_Ctrl_E=0000.
  - Write x0=32'h1234. Required: a later read of x0 returns 0.
- Immediates:
  - ADDI x1,x0,-1 (32'hFFF00093) -> Imm_E=32'hFFFFFFFF, ALU_Src_E=1.
  - SW x2,8(x3) (32'h0021A423) -> Imm_E=8, Mem_Write_E=1, Reg_Write_E=0.
  - JAL x1,-4 (32'hFFDFF0EF) -> Imm_E=32'hFFFFFFFC, Jump_E=1, Result_Src_E=10.
- Flush/stall priority:
  - Load a valid SUB; assert Stall_E for 2 cycles with changing Instr_D -> outputs held.
  - Assert Flush_E and Stall_E together -> all *_E = 0.
- Bypass, with REGFILE_BYPASS_EN defined: Reg_Write_W=1, Rd_W=7, Result_W=32'h55 in the same cycle as Instr_D reads x7 -> RD1_E=32'h55. Without the macro, RD1_E = the old x7 value.
- SRAI x4,x4,3 (32'h40325213) -> ALU_Ctrl_E=0111, Imm_E[4:0]=3. Unknown opcode 32'h0000007F -> all control outputs 0.
